// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 ALUOp encodings, R-type opcodes and ALU control codes.
package legv8_pkg;
    typedef enum logic [1:0] {
        ALUOP_MEM = 2'b00,
        ALUOP_CBZ = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_INV = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100,
        ALU_INV   = 4'b1111
    } alu_ctrl_e;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    function automatic alu_ctrl_e decode_r(input logic [10:0] opcode);
        return opcode == OPC_ADD ? ALU_ADD :
               opcode == OPC_SUB ? ALU_SUB :
               opcode == OPC_AND ? ALU_AND :
               opcode == OPC_ORR ? ALU_ORR : ALU_INV;
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: 64-bit word data memory with synchronous write/clear and combinational gated read.
module dmem_array #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);
    logic [63:0] mem_q [DEPTH];

    // Reset wins over a coincident store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_comb rdata_o = re_i ? mem_q[addr_i] : 64'h0;
endmodule

// File: rtl/ex_mem_datapath.sv
// ex_mem_datapath: LEGv8 ALU control decode, 64-bit ALU with zero flag, and data memory access.
module ex_mem_datapath
    import legv8_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  alu_op,
    input  logic [10:0] opcode,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [63:0] write_data,
    output logic [3:0]  alu_ctrl,
    output logic [63:0] alu_result,
    output logic        zero,
    output logic [63:0] read_data
);
    always_comb begin
        alu_ctrl = alu_op == ALUOP_MEM ? ALU_ADD :
                   alu_op == ALUOP_CBZ ? ALU_PASSB :
                   alu_op == ALUOP_R   ? decode_r(opcode) : ALU_INV;
    end

    always_comb begin
        alu_result = 64'h0;
        case (alu_ctrl)
            ALU_AND:   alu_result = op_a & op_b;
            ALU_ORR:   alu_result = op_a | op_b;
            ALU_ADD:   alu_result = op_a + op_b;
            ALU_SUB:   alu_result = op_a - op_b;
            ALU_PASSB: alu_result = op_b;
            ALU_NOR:   alu_result = ~(op_a | op_b);
            default:   alu_result = 64'h0;
        endcase
    end

    always_comb zero = alu_result == 64'h0;

    // Byte address: low 3 bits select within a word and are dropped; upper bits wrap.
    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_dmem (
        .clk    (clk),
        .reset  (reset),
        .we_i   (mem_write),
        .re_i   (mem_read),
        .addr_i (alu_result[AW+2:3]),
        .wdata_i(write_data),
        .rdata_o(read_data)
    );
endmodule

// File: tb/tb_ex_mem_datapath.sv
// tb_ex_mem_datapath: directed test-plan cases plus randomized traffic against a behavioural model.
module tb_ex_mem_datapath;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  alu_op = '0;
    logic [10:0] opcode = '0;
    logic [63:0] op_a = '0, op_b = '0, write_data = '0;
    logic        mem_write = 1'b0, mem_read = 1'b0;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_result, read_data;
    logic        zero;

    logic [63:0] model_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_datapath #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .alu_op(alu_op), .opcode(opcode),
        .op_a(op_a), .op_b(op_b), .mem_write(mem_write), .mem_read(mem_read),
        .write_data(write_data), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .zero(zero), .read_data(read_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [10:0] opc);
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd7;
        if (op == 2'd3) return 4'd15;
        if (opc == 11'h458) return 4'd2;
        if (opc == 11'h658) return 4'd6;
        if (opc == 11'h450) return 4'd0;
        if (opc == 11'h550) return 4'd1;
        return 4'd15;
    endfunction

    function automatic logic [63:0] ref_alu(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        if (c == 4'd0)  return a & b;
        if (c == 4'd1)  return a | b;
        if (c == 4'd2)  return a + b;
        if (c == 4'd6)  return a - b;
        if (c == 4'd7)  return b;
        if (c == 4'd12) return ~(a | b);
        return 64'h0;
    endfunction

    // Drive one cycle, check combinational outputs before the edge, then advance the model.
    task automatic apply(input string tag, input logic [1:0] op, input logic [10:0] opc,
                         input logic [63:0] a, input logic [63:0] b, input logic we,
                         input logic re, input logic [63:0] wd, input logic rst);
        logic [3:0]  ec;
        logic [63:0] er;
        int          idx;
        alu_op = op; opcode = opc; op_a = a; op_b = b;
        mem_write = we; mem_read = re; write_data = wd; reset = rst;
        #1;
        ec  = ref_ctrl(op, opc);
        er  = ref_alu(ec, a, b);
        idx = int'((er / 64'd8) % 64'(DEPTH));
        check({tag, ".ctrl"}, 64'(alu_ctrl), 64'(ec));
        check({tag, ".res"}, alu_result, er);
        check({tag, ".zero"}, 64'(zero), 64'(er == 64'h0));
        check({tag, ".rd"}, read_data, re ? model_mem[idx] : 64'h0);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'h0;
        end else if (we) begin
            model_mem[idx] = wd;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'h0;
        @(negedge clk);
        apply("rst", 2'd0, 11'h0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1);
        apply("rst_rd0", 2'd0, 11'h0, 64'd40, 64'd0, 1'b0, 1'b1, 64'd0, 1'b0);
        // Decode sweep
        apply("dec_add", 2'b10, 11'b10001011000, 64'd3, 64'd4, 1'b0, 1'b0, 64'd0, 1'b0);
        apply("dec_sub", 2'b10, 11'b11001011000, 64'd9, 64'd4, 1'b0, 1'b0, 64'd0, 1'b0);
        apply("dec_and", 2'b10, 11'b10001010000, 64'hF0F0, 64'hFF00, 1'b0, 1'b0, 64'd0, 1'b0);
        apply("dec_orr", 2'b10, 11'b10101010000, 64'hF0F0, 64'hFF00, 1'b0, 1'b0, 64'd0, 1'b0);
        apply("dec_mem", 2'b00, 11'h7FF, 64'd1, 64'd2, 1'b0, 1'b0, 64'd0, 1'b0);
        apply("dec_cbz", 2'b01, 11'h0, 64'd1, 64'd2, 1'b0, 1'b0, 64'd0, 1'b0);
        apply("dec_inv", 2'b10, 11'b11111000010, 64'd5, 64'd6, 1'b0, 1'b0, 64'd0, 1'b0);
        apply("dec_op11", 2'b11, 11'b10001011000, 64'd5, 64'd6, 1'b0, 1'b0, 64'd0, 1'b0);
        // Arithmetic / logic / CBZ edges
        apply("add_wrap", 2'b10, 11'b10001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b0);
        apply("sub_neg", 2'b10, 11'b11001011000, 64'd5, 64'd7, 1'b0, 1'b0, 64'd0, 1'b0);
        apply("cbz_0", 2'b01, 11'h0, 64'd9, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        apply("cbz_3", 2'b01, 11'h0, 64'd9, 64'd3, 1'b0, 1'b0, 64'd0, 1'b0);
        // Store/load, sub-word and wrap aliasing
        apply("st24", 2'b00, 11'h0, 64'd16, 64'd8, 1'b1, 1'b0, 64'hDEAD_BEEF, 1'b0);
        apply("ld24", 2'b00, 11'h0, 64'd16, 64'd8, 1'b0, 1'b1, 64'd0, 1'b0);
        apply("ld25", 2'b00, 11'h0, 64'd17, 64'd8, 1'b0, 1'b1, 64'd0, 1'b0);
        apply("ldwrap", 2'b00, 11'h0, 64'd16 + 64'(DEPTH * 8), 64'd8, 1'b0, 1'b1, 64'd0, 1'b0);
        // Read-during-write
        apply("rdw_st1", 2'b00, 11'h0, 64'd48, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0);
        apply("rdw_old", 2'b00, 11'h0, 64'd48, 64'd0, 1'b1, 1'b1, 64'd2, 1'b0);
        apply("rdw_new", 2'b00, 11'h0, 64'd48, 64'd0, 1'b0, 1'b1, 64'd0, 1'b0);
        apply("rd_off", 2'b00, 11'h0, 64'd48, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        // Reset has priority over a coincident store
        apply("rs_st3", 2'b00, 11'h0, 64'd24, 64'd0, 1'b1, 1'b0, 64'h55, 1'b0);
        apply("rs_pre3", 2'b00, 11'h0, 64'd24, 64'd0, 1'b0, 1'b1, 64'd0, 1'b0);
        apply("rs_rst", 2'b00, 11'h0, 64'd32, 64'd0, 1'b1, 1'b0, 64'hAA, 1'b1);
        apply("rs_w3", 2'b00, 11'h0, 64'd24, 64'd0, 1'b0, 1'b1, 64'd0, 1'b0);
        apply("rs_w4", 2'b00, 11'h0, 64'd32, 64'd0, 1'b0, 1'b1, 64'd0, 1'b0);
        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [10:0] opc;
            logic [1:0]  op;
            logic [63:0] a, b;
            int          sel;
            sel = int'($urandom_range(0, 4));
            opc = sel == 0 ? 11'h458 : sel == 1 ? 11'h658 : sel == 2 ? 11'h450 :
                  sel == 3 ? 11'h550 : 11'($urandom);
            op  = 2'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 600));
            b   = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 600));
            apply("rnd", op, opc, a, b, 1'($urandom), 1'($urandom),
                  {$urandom, $urandom}, $urandom_range(0, 40) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
